pipe_phy_responder: RTL

PHY-side PIPE command responder. It is the counterpart of the MAC/LTSSM PIPE outputs: it consumes TxDetectRx_Loopback, TxElecIdle, PowerDown and Rate, and returns PhyStatus/RxStatus completions with programmable latencies. It is the PHY model in the loopback benches and the PHY-status shim for FPGA bring-up. All lanes share one command FSM; completions are reported per lane.

---
 rtl/pipe_phy_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_phy_responder.sv
// PHY-side PIPE command responder: one shared command FSM answers rate, power-down
// and receiver-detect requests with PhyStatus/RxStatus completions after fixed latencies.

module pipe_phy_lane (
  input  logic [3:0] pd,
  input  logic [3:0] pdQ,
  input  logic       detKind,
  input  logic       maskBit,
  input  logic       presBit,
  output logic       pdDiff,
  output logic       inP1,
  output logic [2:0] rxDone
);
  assign pdDiff = (pd != pdQ);
  assign inP1   = (pdQ == 4'd2);
  assign rxDone = (detKind && maskBit && presBit) ? 3'b011 : 3'b000;
endmodule

module pipe_phy_responder #(
  parameter int LANESNUMBER    = 16,
  parameter int RESET_LATENCY  = 4,
  parameter int DETECT_LATENCY = 8,
  parameter int PD_LATENCY     = 3,
  parameter int RATE_LATENCY   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]   TxElecIdle,
  input  logic [4*LANESNUMBER-1:0] PowerDown,
  input  logic [3:0]               Rate,
  input  logic [LANESNUMBER-1:0]   RxPresent,
  output logic [LANESNUMBER-1:0]   PhyStatus,
  output logic [3*LANESNUMBER-1:0] RxStatus,
  output logic                     busy
);
  localparam int M0 = (RESET_LATENCY > DETECT_LATENCY) ? RESET_LATENCY : DETECT_LATENCY;
  localparam int M1 = (PD_LATENCY > RATE_LATENCY) ? PD_LATENCY : RATE_LATENCY;
  localparam int MAXLAT = (M0 > M1) ? M0 : M1;
  localparam int CW = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  typedef enum logic [2:0] {RST_HOLD, IDLE, WAIT, DONE, DET_REL} state_t;
  typedef enum logic [1:0] {K_RATE, K_PD, K_DET} kind_t;

  state_t state, nextState;
  kind_t  kind;
  logic [CW-1:0] cnt, cntNext;
  logic [4*LANESNUMBER-1:0] pdQ;
  logic [3:0] rateQ;
  logic [LANESNUMBER-1:0] mask, pres, det, pdDiff, inP1;
  logic [3*LANESNUMBER-1:0] rxDone;
  logic loadRate, loadPd, loadDet;

  assign det = TxDetectRx_Loopback & TxElecIdle;

  for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
    pipe_phy_lane uLane (
      .pd      (PowerDown[4*i +: 4]),
      .pdQ     (pdQ[4*i +: 4]),
      .detKind (kind == K_DET),
      .maskBit (mask[i]),
      .presBit (pres[i]),
      .pdDiff  (pdDiff[i]),
      .inP1    (inP1[i]),
      .rxDone  (rxDone[3*i +: 3])
    );
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    loadRate  = 1'b0;
    loadPd    = 1'b0;
    loadDet   = 1'b0;
    case (state)
      RST_HOLD: if (cnt == '0) nextState = IDLE; else cntNext = cnt - CW'(1);
      IDLE: begin
        // Fixed priority keeps simultaneous requests serialised: rate, then PD, then detect.
        if (Rate != rateQ) begin
          loadRate = 1'b1; cntNext = CW'(RATE_LATENCY - 2); nextState = WAIT;
        end else if (|pdDiff) begin
          loadPd = 1'b1; cntNext = CW'(PD_LATENCY - 2); nextState = WAIT;
        end else if ((|det) && (&inP1)) begin
          loadDet = 1'b1; cntNext = CW'(DETECT_LATENCY - 2); nextState = WAIT;
        end
      end
      WAIT: if (cnt == '0) nextState = DONE; else cntNext = cnt - CW'(1);
      DONE: nextState = (kind == K_DET) ? DET_REL : IDLE;
      // Hold until the detect request drops so a held request cannot retrigger.
      DET_REL: if ((TxDetectRx_Loopback & mask) == '0) nextState = IDLE;
      default: nextState = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_HOLD;
      cnt       <= CW'(RESET_LATENCY - 1);
      pdQ       <= PowerDown;
      rateQ     <= Rate;
      mask      <= '0;
      pres      <= '0;
      kind      <= K_RATE;
      PhyStatus <= '1;
      RxStatus  <= '0;
      busy      <= 1'b1;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      if (loadRate) begin
        rateQ <= Rate; mask <= '1; kind <= K_RATE;
      end
      if (loadPd) begin
        pdQ <= PowerDown; mask <= pdDiff; kind <= K_PD;
      end
      if (loadDet) begin
        mask <= det; pres <= RxPresent; kind <= K_DET;
      end
      PhyStatus <= (nextState == RST_HOLD) ? '1 : (nextState == DONE) ? mask : '0;
      RxStatus  <= (nextState == DONE) ? rxDone : '0;
      busy      <= (nextState != IDLE);
    end
  end
endmodule
